// File: rtl/set12_time_setter.sv
// 12-hour clock time setter: walks AM/PM, hour and minute fields with up/down
// buttons (including hold-to-repeat) and pulses done when the user commits.
module set12_time_setter #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       initIsPM,
   input  logic [3:0] initHours,
   input  logic [5:0] initMinutes,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       btnNext,
   input  logic       btnConfirm,
   output logic       isPM,
   output logic [3:0] hours,
   output logic [5:0] minutes,
   output logic       editing,
   output logic [1:0] field,
   output logic       done
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EDIT_AMPM,
      S_EDIT_HOUR,
      S_EDIT_MIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          isPM_q, isPM_d;
   logic [3:0]    hours_q, hours_d;
   logic [5:0]    minutes_q, minutes_d;
   logic          editing_q, editing_d;
   logic [1:0]    field_q, field_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rep_phase_q, rep_phase_d;
   logic          armed_q, armed_d;
   logic          prev_single_q, prev_single_d;
   logic          prev_up_q, prev_up_d;

   logic          single;
   logic          new_press;
   logic          do_step;
   logic [CW-1:0] cnt_inc;

   always_comb begin
      state_d       = state_q;
      isPM_d        = isPM_q;
      hours_d       = hours_q;
      minutes_d     = minutes_q;
      cnt_d         = cnt_q;
      rep_phase_d   = rep_phase_q;
      armed_d       = armed_q;
      do_step       = 1'b0;
      single        = btnUp ^ btnDown;
      // Switching directly from one button to the other is also a fresh press.
      new_press     = single & (~prev_single_q | (prev_up_q != btnUp));
      cnt_inc       = cnt_q + 1'b1;
      prev_single_d = single;
      prev_up_d     = btnUp;

      case (state_q)
         S_IDLE: begin
            armed_d     = 1'b0;
            cnt_d       = '0;
            rep_phase_d = 1'b0;
            if (start) begin
               state_d   = S_EDIT_AMPM;
               isPM_d    = initIsPM;
               hours_d   = (initHours == 4'd0 || initHours > 4'd12) ? 4'd12 : initHours;
               minutes_d = (initMinutes > 6'd59) ? 6'd0 : initMinutes;
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            armed_d     = 1'b0;
            cnt_d       = '0;
            rep_phase_d = 1'b0;
         end
         default: begin
            if (btnConfirm || btnNext || !single) begin
               armed_d     = 1'b0;
               cnt_d       = '0;
               rep_phase_d = 1'b0;
               if (btnConfirm) begin
                  state_d = S_DONE;
               end else if (btnNext) begin
                  case (state_q)
                     S_EDIT_AMPM: state_d = S_EDIT_HOUR;
                     S_EDIT_HOUR: state_d = S_EDIT_MIN;
                     default:     state_d = S_EDIT_AMPM;
                  endcase
               end
            end else if (new_press) begin
               do_step     = 1'b1;
               armed_d     = 1'b1;
               cnt_d       = '0;
               rep_phase_d = 1'b0;
            end else if (armed_q) begin
               // First wait REPEAT_DELAY after the initial step, then step every REPEAT_PERIOD.
               if (!rep_phase_q && cnt_inc == CW'(REPEAT_DELAY)) begin
                  do_step     = 1'b1;
                  cnt_d       = '0;
                  rep_phase_d = 1'b1;
               end else if (rep_phase_q && cnt_inc == CW'(REPEAT_PERIOD)) begin
                  do_step = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
      endcase

      if (do_step) begin
         case (state_q)
            S_EDIT_AMPM: isPM_d = ~isPM_q;
            S_EDIT_HOUR: begin
               if (btnUp) hours_d = (hours_q == 4'd12) ? 4'd1 : hours_q + 4'd1;
               else       hours_d = (hours_q == 4'd1) ? 4'd12 : hours_q - 4'd1;
            end
            S_EDIT_MIN: begin
               if (btnUp) minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
               else       minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
            end
            default: ;
         endcase
      end

      editing_d = 1'b0;
      field_d   = 2'd3;
      case (state_d)
         S_EDIT_AMPM: begin editing_d = 1'b1; field_d = 2'd0; end
         S_EDIT_HOUR: begin editing_d = 1'b1; field_d = 2'd1; end
         S_EDIT_MIN:  begin editing_d = 1'b1; field_d = 2'd2; end
         default: ;
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         isPM_q        <= 1'b0;
         hours_q       <= 4'd12;
         minutes_q     <= 6'd0;
         editing_q     <= 1'b0;
         field_q       <= 2'd3;
         done_q        <= 1'b0;
         cnt_q         <= '0;
         rep_phase_q   <= 1'b0;
         armed_q       <= 1'b0;
         prev_single_q <= 1'b0;
         prev_up_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         isPM_q        <= isPM_d;
         hours_q       <= hours_d;
         minutes_q     <= minutes_d;
         editing_q     <= editing_d;
         field_q       <= field_d;
         done_q        <= done_d;
         cnt_q         <= cnt_d;
         rep_phase_q   <= rep_phase_d;
         armed_q       <= armed_d;
         prev_single_q <= prev_single_d;
         prev_up_q     <= prev_up_d;
      end
   end

   assign isPM    = isPM_q;
   assign hours   = hours_q;
   assign minutes = minutes_q;
   assign editing = editing_q;
   assign field   = field_q;
   assign done    = done_q;

endmodule

// File: tb/tb_set12_time_setter.sv
// Randomized and directed bench for set12_time_setter, checked every cycle
// against a time-since-press reference model.
module tb_set12_time_setter;

   localparam int D = 4;
   localparam int P = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       init_is_pm = 1'b0;
   logic [3:0] init_hours = 4'd0;
   logic [5:0] init_minutes = 6'd0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_confirm = 1'b0;
   logic       is_pm;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic       editing;
   logic [1:0] field;
   logic       done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: st 0=idle 1=ampm 2=hour 3=min 4=done; k = held cycles since first step.
   int m_st = 0, m_pm = 0, m_h = 12, m_m = 0, m_k = 0;
   bit m_armed = 0, m_prev_single = 0, m_prev_up = 0;

   always #5 clk = ~clk;

   set12_time_setter #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
      .clk(clk), .reset(reset), .start(start), .initIsPM(init_is_pm),
      .initHours(init_hours), .initMinutes(init_minutes),
      .btnUp(btn_up), .btnDown(btn_down), .btnNext(btn_next), .btnConfirm(btn_confirm),
      .isPM(is_pm), .hours(hours), .minutes(minutes),
      .editing(editing), .field(field), .done(done)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_apply_step(input bit up);
      case (m_st)
         1: m_pm = 1 - m_pm;
         2: m_h = up ? (m_h % 12) + 1 : ((m_h + 10) % 12) + 1;
         3: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
         default: ;
      endcase
   endtask

   task automatic model_update();
      bit single, newp;
      single = btn_up ^ btn_down;
      newp = single && (!m_prev_single || (m_prev_up != btn_up));
      if (reset) begin
         m_st = 0; m_pm = 0; m_h = 12; m_m = 0; m_k = 0; m_armed = 0;
         single = 0;
      end else if (m_st == 0) begin
         m_armed = 0;
         if (start) begin
            m_st = 1;
            m_pm = int'(init_is_pm);
            m_h = (init_hours == 0 || init_hours > 12) ? 12 : int'(init_hours);
            m_m = (init_minutes > 59) ? 0 : int'(init_minutes);
         end
      end else if (m_st == 4) begin
         m_st = 0; m_armed = 0;
      end else if (btn_confirm) begin
         m_st = 4; m_armed = 0;
      end else if (btn_next) begin
         m_st = (m_st == 3) ? 1 : m_st + 1; m_armed = 0;
      end else if (!single) begin
         m_armed = 0;
      end else if (newp) begin
         model_apply_step(btn_up); m_armed = 1; m_k = 0;
      end else if (m_armed) begin
         m_k++;
         if (m_k == D || (m_k > D && (m_k - D) % P == 0)) model_apply_step(btn_up);
      end
      m_prev_single = reset ? 0 : single;
      m_prev_up = reset ? 0 : btn_up;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      cyc++;
      chk("isPM", int'(is_pm), m_pm);
      chk("hours", int'(hours), m_h);
      chk("minutes", int'(minutes), m_m);
      chk("editing", int'(editing), (m_st >= 1 && m_st <= 3) ? 1 : 0);
      chk("field", int'(field), (m_st >= 1 && m_st <= 3) ? m_st - 1 : 3);
      chk("done", int'(done), (m_st == 4) ? 1 : 0);
      $display("cyc=%0d rst=%0d st=%0d up=%0d dn=%0d nx=%0d cf=%0d -> pm=%0d h=%0d m=%0d f=%0d dn=%0d",
               cyc, reset, start, btn_up, btn_down, btn_next, btn_confirm,
               is_pm, hours, minutes, field, done);
      reset = 1'b0; start = 1'b0; btn_next = 1'b0; btn_confirm = 1'b0;
   endtask

   task automatic do_start(input bit pm, input int h, input int m);
      start = 1'b1; init_is_pm = pm; init_hours = 4'(h); init_minutes = 6'(m);
      tick();
   endtask

   task automatic do_next();
      btn_next = 1'b1; tick();
   endtask

   task automatic pulse_btn(input bit up);
      btn_up = up; btn_down = !up; tick();
      btn_up = 1'b0; btn_down = 1'b0; tick();
   endtask

   initial begin
      reset = 1'b1; tick();
      chk("reset_hours", int'(hours), 12);
      chk("reset_field", int'(field), 3);

      // V1: hour wrap 11->12->1, isPM untouched
      do_start(1, 11, 58); do_next();
      pulse_btn(1); chk("v1_h12", int'(hours), 12); chk("v1_pm", int'(is_pm), 1);
      pulse_btn(1); chk("v1_h1", int'(hours), 1);
      btn_confirm = 1'b1; tick(); tick();

      // V2: minute wrap both ways
      do_start(0, 5, 59); do_next(); do_next();
      pulse_btn(1); chk("v2_m0", int'(minutes), 0);
      pulse_btn(0); chk("v2_m59", int'(minutes), 59);
      pulse_btn(1); pulse_btn(0); chk("v2_m59b", int'(minutes), 59);
      btn_confirm = 1'b1; tick(); tick();

      // V3: sanitising
      do_start(0, 14, 61);
      chk("v3_h", int'(hours), 12); chk("v3_m", int'(minutes), 0);

      // V4: auto-repeat from 10
      reset = 1'b1; tick();
      do_start(0, 3, 10); do_next(); do_next();
      btn_up = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      btn_up = 1'b0; tick();
      chk("v4_m14", int'(minutes), 14);

      // V5: confirm beats step in EDIT_HOUR
      do_next(); do_next();
      btn_confirm = 1'b1; btn_up = 1'b1; tick();
      chk("v5_done", int'(done), 1); chk("v5_h", int'(hours), 3);
      btn_up = 1'b0; tick();
      chk("v5_done_off", int'(done), 0); chk("v5_edit", int'(editing), 0);

      // V6: reset in EDIT_MIN
      do_start(1, 7, 30); do_next(); do_next();
      reset = 1'b1; tick();
      chk("v6_pm", int'(is_pm), 0); chk("v6_h", int'(hours), 12); chk("v6_m", int'(minutes), 0);
      tick(); chk("v6_nodone", int'(done), 0);

      // Randomized phase
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) reset = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1;
            init_is_pm = 1'($urandom);
            init_hours = 4'($urandom);
            init_minutes = 6'($urandom);
         end
         if ($urandom_range(0, 11) == 0) btn_next = 1'b1;
         if ($urandom_range(0, 39) == 0) btn_confirm = 1'b1;
         if ($urandom_range(0, 5) == 0) begin
            btn_up = 1'($urandom);
            btn_down = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/set12_time_setter.md
SET12_TIME_SETTER -- requirements
Module: set12_time_setter

Interface
- REQ-001 SHALL have parameter REPEAT_DELAY, default 50_000_000: cycles a held step button waits before auto-repeat starts.
- REQ-002 SHALL have parameter REPEAT_PERIOD, default 10_000_000: cycles between auto-repeat steps, REPEAT_PERIOD >= 1.
- REQ-003 SHALL have one clock and a synchronous, active-high reset, with the ports below in order.
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - start  in  1  one-cycle pulse; enters edit mode.
  - initIsPM  in  1  value loaded into isPM on start.
  - initHours  in  4  value loaded into hours on start.
  - initMinutes  in  6  value loaded into minutes on start.
  - btnUp  in  1  debounced level; increment.
  - btnDown  in  1  debounced level; decrement.
  - btnNext  in  1  one-cycle pulse; advance field.
  - btnConfirm  in  1  one-cycle pulse; commit.
  - isPM  out  1  1 = PM, 0 = AM; feeds the 12-hour display decoder.
  - hours  out  4  1..12; feeds the 12-hour display decoder.
  - minutes  out  6  0..59; feeds the 12-hour display decoder.
  - editing  out  1  high in any EDIT state.
  - field  out  2  0 = AMPM, 1 = HOUR, 2 = MIN, 3 = none.
  - done  out  1  one-cycle commit pulse.
- REQ-004 SHALL register all outputs; no combinational input-to-output path.

Function
- REQ-005 SHALL have states IDLE, EDIT_AMPM, EDIT_HOUR, EDIT_MIN, DONE.
- REQ-006 In IDLE, start=1 SHALL enter EDIT_AMPM next cycle and load the init values, with sanitising:
  - initHours 0 or 13..15 loads 12.
  - initMinutes 60..63 loads 0.
- REQ-007 start SHALL be ignored outside IDLE.
- REQ-008 btnNext SHALL cycle EDIT_AMPM -> EDIT_HOUR -> EDIT_MIN -> EDIT_AMPM, one transition per pulse.
- REQ-009 btnConfirm in any EDIT state SHALL go to DONE.
- REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- REQ-011 field SHALL be 0/1/2 in EDIT_AMPM/EDIT_HOUR/EDIT_MIN and 3 in IDLE/DONE; editing SHALL be 1 only in EDIT states.
- REQ-012 Same-cycle priority SHALL be: reset > btnConfirm > btnNext > step.
  - A cycle taking confirm or next SHALL not step.
- REQ-013 A step SHALL fire in the cycle after btnUp XOR btnDown rises to 1.
- REQ-014 Auto-repeat SHALL apply while the same single button stays held:
  - further steps at REPEAT_DELAY cycles after the first step;
  - then every REPEAT_PERIOD cycles.
- REQ-015 btnUp and btnDown both high SHALL produce no step and clear the repeat counter.
  - Releasing one button SHALL count as a new press of the remaining one.
- REQ-016 A field change via btnNext SHALL clear the repeat counter; no step until a new press.
- REQ-017 Step on AMPM SHALL toggle isPM, for either direction.
- REQ-018 Step on HOUR SHALL be: up 1..11 -> +1, up 12 -> 1, down 2..12 -> -1, down 1 -> 12.
  - isPM SHALL NOT change on hour wrap.
- REQ-019 Step on MIN SHALL be: up 59 -> 0, down 0 -> 59, otherwise ±1.
- REQ-020 Steps SHALL only modify the field currently selected.
- REQ-021 Outputs SHALL hold their values in IDLE and DONE; buttons SHALL be ignored there.
- REQ-022 hours SHALL always be in 1..12 and minutes in 0..59.

Reset
- REQ-023 reset=1 SHALL, at the next edge, force state IDLE, isPM=0, hours=12, minutes=0, editing=0, field=3, done=0, and clear repeat logic.
- REQ-024 reset during EDIT or DONE SHALL abort without a done pulse.
- REQ-025 reset SHALL override start in the same cycle.

Verification
- V1: reset; start with init (1, 11, 58); Next; Up pulse -> hours=12, isPM=1 unchanged; Up -> hours=1.
- V2: init minutes=59; Next ×2; Up -> minutes=0; Down -> 59; Down from 0 behaves likewise.
- V3: init hours=14, minutes=61 -> loaded hours=12, minutes=0.
- V4: REPEAT_DELAY=4, REPEAT_PERIOD=2; MIN field, hold btnUp 10 cycles from 10 -> minutes 10→11 (edge), 12 (+4), 13 (+6), 14 (+8).
- V5: btnConfirm and btnUp in same cycle in EDIT_HOUR -> no step, done=1 one cycle, then field=3, editing=0.
- V6: reset asserted in EDIT_MIN -> next cycle isPM=0, hours=12, minutes=0, done never pulses.
